matrix_stream_loader: RTL

//   Upstream feeder for the matrix-by-matrix multiplier. Accepts matrix elements one per beat on a

---
 rtl/matrix_stream_loader.sv | 110 +++++++++++
 1 files changed

// File: rtl/matrix_stream_loader.sv
// Stream-to-operand loader for the matrix multiplier: packs matrix 1 then matrix 2 from a
// valid/ready element stream, fires a one-cycle calc pulse and holds operands until completion.
module matrix_stream_loader #(
   parameter int FIRST_MATRIX_HEIGHT = 5,
   parameter int BOTH_MATRIX_W_H     = 5,
   parameter int SECOND_MATRIX_WIDTH = 5,
   parameter int DATA_WIDTH          = 8,
   parameter int FIRST_MATRIX_WEIGHT  = FIRST_MATRIX_HEIGHT * BOTH_MATRIX_W_H,
   parameter int SECOND_MATRIX_WEIGHT = BOTH_MATRIX_W_H * SECOND_MATRIX_WIDTH,
   parameter int FIRST_MATRIX_SIZE    = FIRST_MATRIX_WEIGHT * DATA_WIDTH,
   parameter int SECOND_MATRIX_SIZE   = SECOND_MATRIX_WEIGHT * DATA_WIDTH,
   parameter int CNT_W = $clog2(((FIRST_MATRIX_WEIGHT > SECOND_MATRIX_WEIGHT) ?
                                 FIRST_MATRIX_WEIGHT : SECOND_MATRIX_WEIGHT) + 1)
) (
   input  logic                          clk,
   input  logic                          i_rst,
   input  logic [DATA_WIDTH-1:0]         i_data,
   input  logic                          i_valid,
   output logic                          o_ready,
   output logic [FIRST_MATRIX_SIZE-1:0]  o_matrix_1,
   output logic [SECOND_MATRIX_SIZE-1:0] o_matrix_2,
   output logic                          o_calc,
   input  logic                          i_mult_ready,
   output logic                          o_busy
);

   typedef enum logic [2:0] {
      LOAD1   = 3'd0,
      LOAD2   = 3'd1,
      START   = 3'd2,
      WAIT_LO = 3'd3,
      WAIT_HI = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LAST_1 = CNT_W'(FIRST_MATRIX_WEIGHT - 1);
   localparam logic [CNT_W-1:0] LAST_2 = CNT_W'(SECOND_MATRIX_WEIGHT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             beat;

   // o_ready is a flop, so the handshake never loops back through i_valid
   assign beat = i_valid && o_ready;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state      <= LOAD1;
         cnt        <= '0;
         o_matrix_1 <= '0;
         o_matrix_2 <= '0;
         o_calc     <= 1'b0;
         o_busy     <= 1'b0;
         o_ready    <= 1'b1;
      end else begin
         o_calc <= 1'b0;
         case (state)
            LOAD1: begin
               if (beat) begin
                  for (int k = 0; k < FIRST_MATRIX_WEIGHT; k++) begin
                     if (cnt == CNT_W'(k)) o_matrix_1[k*DATA_WIDTH +: DATA_WIDTH] <= i_data;
                  end
                  if (cnt == LAST_1) begin
                     cnt   <= '0;
                     state <= LOAD2;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            LOAD2: begin
               if (beat) begin
                  for (int k = 0; k < SECOND_MATRIX_WEIGHT; k++) begin
                     if (cnt == CNT_W'(k)) o_matrix_2[k*DATA_WIDTH +: DATA_WIDTH] <= i_data;
                  end
                  if (cnt == LAST_2) begin
                     cnt     <= '0;
                     state   <= START;
                     o_ready <= 1'b0;
                     o_calc  <= 1'b1;
                     o_busy  <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            START: begin
               state <= WAIT_LO;
            end
            // a ready left over from the previous job must not read as completion
            WAIT_LO: begin
               if (!i_mult_ready) state <= WAIT_HI;
            end
            WAIT_HI: begin
               if (i_mult_ready) begin
                  state   <= LOAD1;
                  o_busy  <= 1'b0;
                  o_ready <= 1'b1;
               end
            end
            default: begin
               state   <= LOAD1;
               cnt     <= '0;
               o_busy  <= 1'b0;
               o_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
